// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: register map, sequence steps, FSM states and AXI constants for the AES job sequencer
package aes_seq_pkg;
  localparam int WORDS = 4;
  localparam logic [31:0] KEY0_OFF = 32'h00;
  localparam logic [31:0] DIN0_OFF = 32'h10;
  localparam logic [31:0] CTRL_OFF = 32'h20;
  localparam logic [31:0] STATUS_OFF = 32'h24;
  localparam logic [31:0] DOUT0_OFF = 32'h28;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  // One step index walks the whole job: 0-3 KEY, 4-7 DIN, 8 CTRL, 9 STATUS, 10-13 DOUT
  localparam logic [3:0] ST_DIN0 = 4'd4;
  localparam logic [3:0] ST_CTRL = 4'd8;
  localparam logic [3:0] ST_STATUS = 4'd9;
  localparam logic [3:0] ST_DOUT0 = 4'd10;
  localparam logic [3:0] ST_DOUT3 = ST_DOUT0 + 4'(WORDS - 1);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESULT} seq_state_t;
  function automatic logic [31:0] step_off(input logic [3:0] s);
    return s < ST_DIN0 ? KEY0_OFF + {28'b0, s[1:0], 2'b0} :
           s < ST_CTRL ? DIN0_OFF + {28'b0, s[1:0], 2'b0} :
           s == ST_CTRL ? CTRL_OFF :
           s == ST_STATUS ? STATUS_OFF : DOUT0_OFF + {28'b0, s[1:0] - 2'd2, 2'b0};
  endfunction
endpackage

// File: rtl/aes_job_sequencer_if.sv
// aes_job_sequencer_if: AXI4-Lite bus between the AES job sequencer and the AES peripheral
interface aes_job_sequencer_if;
  logic [31:0] M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID, M_AXI_ARREADY,
           M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID, M_AXI_ARREADY,
           M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/aes_axil_single_txn.sv
// aes_axil_single_txn: one AXI4-Lite read or write at a time; caller holds addr/wdata until done
module aes_axil_single_txn (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        req_done,
  output logic        done,
  output logic [1:0]  resp,
  output logic [31:0] rdata,
  aes_job_sequencer_if.master m
);
  logic aw_v, w_v, ar_v, b_r, r_r, aw_hs, w_hs, ar_hs, wr_req_done;
  always_comb begin
    aw_hs = aw_v & m.M_AXI_AWREADY;
    w_hs = w_v & m.M_AXI_WREADY;
    ar_hs = ar_v & m.M_AXI_ARREADY;
    wr_req_done = (aw_v | w_v) & (~aw_v | aw_hs) & (~w_v | w_hs);
    req_done = wr_req_done | ar_hs;
    done = (b_r & m.M_AXI_BVALID) | (r_r & m.M_AXI_RVALID);
    resp = b_r ? m.M_AXI_BRESP : m.M_AXI_RRESP;
    rdata = m.M_AXI_RDATA;
  end
  assign m.M_AXI_AWADDR = addr;
  assign m.M_AXI_AWPROT = 3'b000;
  assign m.M_AXI_AWVALID = aw_v;
  assign m.M_AXI_WDATA = wdata;
  assign m.M_AXI_WSTRB = 4'hF;
  assign m.M_AXI_WVALID = w_v;
  assign m.M_AXI_BREADY = b_r;
  assign m.M_AXI_ARADDR = addr;
  assign m.M_AXI_ARPROT = 3'b000;
  assign m.M_AXI_ARVALID = ar_v;
  assign m.M_AXI_RREADY = r_r;
  // BREADY rises only once both AW and W have handshaken
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      aw_v <= 1'b0;
      w_v <= 1'b0;
      ar_v <= 1'b0;
      b_r <= 1'b0;
      r_r <= 1'b0;
    end else begin
      aw_v <= start ? wr : aw_v & ~m.M_AXI_AWREADY;
      w_v <= start ? wr : w_v & ~m.M_AXI_WREADY;
      ar_v <= start ? ~wr : ar_v & ~m.M_AXI_ARREADY;
      b_r <= wr_req_done | (b_r & ~m.M_AXI_BVALID);
      r_r <= ar_hs | (r_r & ~m.M_AXI_RVALID);
    end
endmodule

// File: rtl/aes_job_sequencer.sv
// aes_job_sequencer: runs one AES job over AXI4-Lite (load key/data, start, poll, read result)
module aes_job_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int POLL_LIMIT = 256
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [127:0] job_key,
  input  logic [127:0] job_data,
  input  logic         job_decrypt,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         res_error,
  aes_job_sequencer_if.master m_axi
);
  import aes_seq_pkg::*;
  localparam int CW = $clog2(POLL_LIMIT + 1);
  seq_state_t st, nxt;
  logic [3:0] step, step_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [127:0] key, din;
  logic dec, start, set_err, load, req_done, done;
  logic [1:0] resp;
  logic [31:0] rdata, wdata;
  assign job_ready = st == IDLE;
  assign res_valid = st == RESULT;
  assign wdata = step < ST_DIN0 ? key[{step[1:0], 5'b0} +: 32] :
                 step < ST_CTRL ? din[{step[1:0], 5'b0} +: 32] : {30'b0, dec, 1'b1};
  aes_axil_single_txn u_txn (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .wr(nxt == WR_REQ),
    .addr(BASE_ADDR + step_off(step)), .wdata(wdata), .req_done(req_done),
    .done(done), .resp(resp), .rdata(rdata), .m(m_axi)
  );
  // start is raised on the transition into a request state so VALID appears with the new step
  always_comb begin
    nxt = st;
    step_n = step;
    cnt_n = cnt;
    start = 1'b0;
    set_err = 1'b0;
    load = 1'b0;
    unique case (st)
      IDLE: if (job_valid) begin
        nxt = WR_REQ;
        step_n = '0;
        cnt_n = '0;
        start = 1'b1;
      end
      WR_REQ: if (req_done) nxt = WR_RESP;
      WR_RESP: if (done && resp != RESP_OKAY) begin
        set_err = 1'b1;
        nxt = RESULT;
      end else if (done) begin
        step_n = step + 4'd1;
        start = 1'b1;
        nxt = step == ST_CTRL ? RD_REQ : WR_REQ;
      end
      RD_REQ: if (req_done) nxt = RD_RESP;
      RD_RESP: if (done && resp != RESP_OKAY) begin
        set_err = 1'b1;
        nxt = RESULT;
      end else if (done && step == ST_STATUS && !rdata[0]) begin
        cnt_n = cnt + CW'(1);
        set_err = cnt_n == CW'(POLL_LIMIT);
        start = !set_err;
        nxt = set_err ? RESULT : RD_REQ;
      end else if (done) begin
        load = step != ST_STATUS;
        step_n = step + 4'd1;
        start = step != ST_DOUT3;
        nxt = step == ST_DOUT3 ? RESULT : RD_REQ;
      end
      RESULT: if (res_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) st <= IDLE;
    else st <= nxt;
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      step <= '0;
      cnt <= '0;
      key <= '0;
      din <= '0;
      dec <= 1'b0;
      res_data <= '0;
      res_error <= 1'b0;
    end else begin
      step <= step_n;
      cnt <= cnt_n;
      if (st == IDLE && job_valid) begin
        key <= job_key;
        din <= job_data;
        dec <= job_decrypt;
        res_data <= '0;
        res_error <= 1'b0;
      end
      if (set_err) res_error <= 1'b1;
      if (load) res_data[{step[1:0] - 2'd2, 5'b0} +: 32] <= rdata;
    end
endmodule

// File: tb/tb_aes_job_sequencer.sv
// tb_aes_job_sequencer: directed checks of the AES job sequencer against a scripted AXI4-Lite slave
module tb_aes_job_sequencer;
  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] DAT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'hfedcba9876543210_0123456789abcdef;
  localparam logic [127:0] DAT2 = 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
  localparam logic [127:0] CT = {32'h70b4c55a, 32'hd8cdb780, 32'h6a7b0430, 32'h69c4e0d8};
  logic ACLK = 1'b0, ARESETN = 1'b0;
  logic job_valid, job_ready, job_decrypt, res_valid, res_ready, res_error;
  logic [127:0] job_key, job_data, res_data;
  aes_job_sequencer_if bus();
  aes_job_sequencer #(.BASE_ADDR(BASE), .POLL_LIMIT(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .job_valid(job_valid), .job_ready(job_ready),
    .job_key(job_key), .job_data(job_data), .job_decrypt(job_decrypt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_error(res_error),
    .m_axi(bus)
  );
  always #5 ACLK = ~ACLK;
  int cmp = 0, errs = 0;
  int aw_dly, w_dly, ar_dly, done_on, st_base, w0, r0;
  logic err_en;
  logic [31:0] err_addr;
  logic [31:0] dout_w [4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
  logic [31:0] wa [256], wd [256], ra [256];
  int nwa = 0, nwd = 0, nra = 0, st_reads = 0, aw_wait, w_wait, ar_wait, proto = 0, res_cnt = 0;
  logic aw_got, w_got, bad;
  logic p_aw, p_w, p_ar, p_res, q_re;
  logic [31:0] q_aw, q_w, q_ar;
  logic [127:0] q_rd, rd;
  logic re;
  assign bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && aw_wait >= aw_dly;
  assign bus.M_AXI_WREADY = bus.M_AXI_WVALID && w_wait >= w_dly;
  assign bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && ar_wait >= ar_dly;
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == BASE + 32'h24) return {31'b0, done_on != 0 && st_reads - st_base + 1 >= done_on};
    for (int n = 0; n < 4; n++) if (a == BASE + 32'h28 + 32'(4 * n)) return dout_w[n];
    return 32'hdead_beef;
  endfunction
  // Slave: configurable ready delays, logs every handshake, optional SLVERR on one address
  always @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; aw_got <= 0; w_got <= 0; bad <= 0;
      bus.M_AXI_BVALID <= 0; bus.M_AXI_BRESP <= 0;
      bus.M_AXI_RVALID <= 0; bus.M_AXI_RRESP <= 0; bus.M_AXI_RDATA <= 0;
    end else begin
      if (bus.M_AXI_AWVALID) aw_wait <= bus.M_AXI_AWREADY ? 0 : aw_wait + 1;
      if (bus.M_AXI_WVALID) w_wait <= bus.M_AXI_WREADY ? 0 : w_wait + 1;
      if (bus.M_AXI_ARVALID) ar_wait <= bus.M_AXI_ARREADY ? 0 : ar_wait + 1;
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
        wa[nwa % 256] <= bus.M_AXI_AWADDR; nwa <= nwa + 1; aw_got <= 1;
        bad <= err_en && bus.M_AXI_AWADDR == err_addr;
      end
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
        wd[nwd % 256] <= bus.M_AXI_WDATA; nwd <= nwd + 1; w_got <= 1;
      end
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) bus.M_AXI_BVALID <= 0;
      if (aw_got && w_got && !bus.M_AXI_BVALID) begin
        bus.M_AXI_BVALID <= 1; bus.M_AXI_BRESP <= bad ? 2'b10 : 2'b00; aw_got <= 0; w_got <= 0;
      end
      if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) bus.M_AXI_RVALID <= 0;
      if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
        ra[nra % 256] <= bus.M_AXI_ARADDR; nra <= nra + 1;
        bus.M_AXI_RVALID <= 1; bus.M_AXI_RRESP <= 2'b00; bus.M_AXI_RDATA <= rd_val(bus.M_AXI_ARADDR);
        if (bus.M_AXI_ARADDR == BASE + 32'h24) st_reads <= st_reads + 1;
      end
    end
  // Protocol monitor: no read/write overlap, VALID and payload held until handshake
  always @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      p_aw <= 0; p_w <= 0; p_ar <= 0; p_res <= 0;
    end else begin
      if ((bus.M_AXI_AWVALID || bus.M_AXI_WVALID || bus.M_AXI_BREADY) &&
          (bus.M_AXI_ARVALID || bus.M_AXI_RREADY)) proto <= proto + 1;
      if (p_aw && (!bus.M_AXI_AWVALID || bus.M_AXI_AWADDR != q_aw)) proto <= proto + 1;
      if (p_w && (!bus.M_AXI_WVALID || bus.M_AXI_WDATA != q_w)) proto <= proto + 1;
      if (p_ar && (!bus.M_AXI_ARVALID || bus.M_AXI_ARADDR != q_ar)) proto <= proto + 1;
      if (p_res && (!res_valid || res_data != q_rd || res_error != q_re)) proto <= proto + 1;
      if (res_valid && res_ready) res_cnt <= res_cnt + 1;
      p_aw <= bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY; q_aw <= bus.M_AXI_AWADDR;
      p_w <= bus.M_AXI_WVALID && !bus.M_AXI_WREADY; q_w <= bus.M_AXI_WDATA;
      p_ar <= bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY; q_ar <= bus.M_AXI_ARADDR;
      p_res <= res_valid && !res_ready; q_rd <= res_data; q_re <= res_error;
    end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start_job(input logic [127:0] k, input logic [127:0] d, input logic dec);
    int t;
    w0 = nwa; r0 = nra; st_base = st_reads;
    @(negedge ACLK);
    job_key = k; job_data = d; job_decrypt = dec; job_valid = 1;
    t = 0;
    while (!job_ready && t < 50) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    job_valid = 0;
    chk("accept_ready_low", job_ready, 0);
  endtask
  task automatic run_job(input logic [127:0] k, input logic [127:0] d, input logic dec);
    int t;
    start_job(k, d, dec);
    t = 0;
    while (!res_valid && t < 3000) begin @(negedge ACLK); t++; end
    chk("result_in_time", t < 3000, 1);
    rd = res_data; re = res_error;
    @(negedge ACLK);
  endtask
  task automatic chk_writes(input logic [127:0] k, input logic [127:0] d, input logic dec);
    logic [31:0] ew;
    chk("wr_aw_count", nwa - w0, 9);
    chk("wr_w_count", nwd - w0, 9);
    for (int i = 0; i < 9; i++) begin
      ew = i < 4 ? k[32 * i +: 32] : i < 8 ? d[32 * (i - 4) +: 32] : {30'b0, dec, 1'b1};
      chk($sformatf("wr_addr%0d", i), wa[(w0 + i) % 256], BASE + 32'(4 * i));
      chk($sformatf("wr_data%0d", i), wd[(w0 + i) % 256], ew);
    end
  endtask
  task automatic chk_reads(input int nst);
    chk("rd_count", nra - r0, nst + 4);
    chk("status_reads", st_reads - st_base, nst);
    for (int i = 0; i < nst; i++) chk($sformatf("rd_status%0d", i), ra[(r0 + i) % 256], BASE + 32'h24);
    for (int n = 0; n < 4; n++) chk($sformatf("rd_dout%0d", n), ra[(r0 + nst + n) % 256], BASE + 32'h28 + 32'(4 * n));
  endtask
  initial begin
    #500000;
    $error("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    job_valid = 0; job_decrypt = 0; job_key = '0; job_data = '0; res_ready = 1;
    aw_dly = 0; w_dly = 0; ar_dly = 1; done_on = 3; err_en = 0; err_addr = '0;
    st_base = 0; w0 = 0; r0 = 0;
    repeat (3) @(negedge ACLK);
    chk("rst_awvalid", bus.M_AXI_AWVALID, 0);
    chk("rst_wvalid", bus.M_AXI_WVALID, 0);
    chk("rst_arvalid", bus.M_AXI_ARVALID, 0);
    chk("rst_bready_rready", {bus.M_AXI_BREADY, bus.M_AXI_RREADY}, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res", {res_error, res_data}, 0);
    ARESETN = 1;
    @(negedge ACLK);
    chk("rst_job_ready", job_ready, 1);
    chk("fixed_prot_strb", {bus.M_AXI_AWPROT, bus.M_AXI_ARPROT, bus.M_AXI_WSTRB}, 10'h00F);
    run_job(KEY, DAT, 0);
    chk_writes(KEY, DAT, 0);
    chk_reads(3);
    chk("enc_data", rd, CT);
    chk("enc_err", re, 0);
    res_ready = 0;
    run_job(KEY, DAT, 1);
    chk_writes(KEY, DAT, 1);
    chk("dec_ctrl", wd[(w0 + 8) % 256], 32'h3);
    chk("dec_data", rd, CT);
    repeat (3) @(negedge ACLK);
    chk("stall_valid", res_valid, 1);
    chk("stall_data", res_data, CT);
    res_ready = 1;
    @(negedge ACLK);
    chk("stall_release", {res_valid, job_ready}, 2'b01);
    aw_dly = 3;
    run_job(KEY2, DAT2, 0);
    chk_writes(KEY2, DAT2, 0);
    chk("awlate_data", {re, rd}, {1'b0, CT});
    aw_dly = 0; w_dly = 3;
    run_job(KEY2, DAT2, 1);
    chk_writes(KEY2, DAT2, 1);
    chk("wlate_data", {re, rd}, {1'b0, CT});
    w_dly = 0; err_en = 1; err_addr = BASE + 32'h14;
    run_job(KEY, DAT, 0);
    chk("slverr_err", re, 1);
    chk("slverr_data", rd, 0);
    chk("slverr_last_addr", wa[(nwa - 1) % 256], BASE + 32'h14);
    repeat (10) @(negedge ACLK);
    chk("slverr_writes", nwa - w0, 6);
    chk("slverr_reads", nra - r0, 0);
    err_en = 0; done_on = 0;
    run_job(KEY, DAT, 0);
    chk("poll_status_reads", st_reads - st_base, 4);
    chk("poll_reads", nra - r0, 4);
    chk("poll_err", re, 1);
    chk("poll_data", rd, 0);
    done_on = 1;
    begin
      int t;
      int rc;
      rc = res_cnt;
      start_job(KEY, DAT, 0);
      t = 0;
      while (!(bus.M_AXI_ARVALID && bus.M_AXI_ARADDR == BASE + 32'h30) && t < 3000) begin
        @(negedge ACLK); t++;
      end
      chk("dout2_reached", t < 3000, 1);
      ARESETN = 0;
      @(negedge ACLK);
      chk("midrst_arvalid", bus.M_AXI_ARVALID, 0);
      chk("midrst_res", {res_valid, res_error, res_data}, 0);
      ARESETN = 1;
      repeat (3) @(negedge ACLK);
      chk("midrst_no_result", {res_valid, 32'(res_cnt - rc)}, 0);
      chk("midrst_ready", job_ready, 1);
    end
    run_job(KEY2, DAT2, 0);
    chk_writes(KEY2, DAT2, 0);
    chk_reads(1);
    chk("restart_data", {re, rd}, {1'b0, CT});
    chk("protocol_violations", proto, 0);
    chk("result_handshakes", res_cnt, 7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
